// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: fixed register
// addresses, status word bit positions and the address-decode helper.
package dmem_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'd1024;
    localparam logic [31:0] ADDR_OVFCNT = 32'd1028;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_TX,
        REG_OVF,
        REG_NONE
    } region_e;

    // Word-granular decode: the two byte-offset bits never take part.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned mem_words);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr < 32'(mem_words * 4))
            return REG_RAM;
        else if (word_addr == ADDR_TXDATA)
            return REG_TX;
        else if (word_addr == ADDR_OVFCNT)
            return REG_OVF;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// Synchronous FIFO used for the console byte stream.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   push, din   : write request and data
//   pop         : read request (ignored while empty)
//   dout        : head entry, 0 while empty
//   full, empty : occupancy flags
//   count       : number of entries held (0..DEPTH)
//   drop        : push refused this cycle (full and no pop)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot at the same edge, so a full FIFO can still
    // take a new byte when it is draining that cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = empty ? '0 : storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            storage[wr_ptr] <= din;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the core load/store port. Serves a word-addressed
// RAM at 0, a console TX data/status register at 1024 and a read-and-clear
// overflow counter at 1028. Console bytes leave through a valid/ready stream.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   mem, mem_read       : access request and direction (1 = load)
//   addr, data_out      : byte address and store data from the core
//   data_in             : combinational load data (0 when no load)
//   tx_valid/ready/data : console byte stream
//   bus_err             : one-cycle pulse after an unmapped access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        bus_err
);

    localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [MEM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    region_e           region;
    logic              is_load;
    logic              is_store;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        ovf_cnt;
    logic              overflow_seen;
    logic              ovf_clr;
    logic [31:0]       status_word;

    assign region    = decode_region(addr, MEM_WORDS);
    assign is_load   = mem && mem_read;
    assign is_store  = mem && !mem_read;
    assign ram_idx   = addr[2 +: RAM_AW];
    assign fifo_push = is_store && (region == REG_TX);
    assign fifo_pop  = tx_valid && tx_ready;
    assign ovf_clr   = is_load && (region == REG_OVF);
    assign tx_valid  = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_out[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (is_store && (region == REG_RAM))
            ram[ram_idx] <= data_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt       <= '0;
            overflow_seen <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            bus_err <= mem && (region == REG_NONE);
            // A drop in the same cycle as a clearing read counts from zero.
            if (fifo_drop) begin
                overflow_seen <= 1'b1;
                if (ovf_clr)
                    ovf_cnt <= 8'd1;
                else if (ovf_cnt != 8'hFF)
                    ovf_cnt <= ovf_cnt + 8'd1;
            end else if (ovf_clr) begin
                ovf_cnt       <= '0;
                overflow_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_FULL]                 = fifo_full;
        status_word[STATUS_EMPTY]                = fifo_empty;
        status_word[STATUS_OVF]                  = overflow_seen;
        status_word[STATUS_COUNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        data_in = '0;
        if (is_load) begin
            case (region)
                REG_RAM:  data_in = ram[ram_idx];
                REG_TX:   data_in = status_word;
                REG_OVF:  data_in = {24'b0, ovf_cnt};
                default:  data_in = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .MEM_WORDS  (256),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem),
        .mem_read (mem_read),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        bit          rd;
        logic [31:0] a;
        logic [31:0] wd;
        bit          rdy;
        logic [31:0] exp_din;
        bit          exp_valid;
        logic [7:0]  exp_txd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are observed 1ns later,
    // i.e. they reflect state from the previous rising edge.
    task automatic step(input bit rst, input bit m, input bit rd,
                        input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        @(negedge clk);
        rst_n    = rst;
        mem      = m;
        mem_read = rd;
        addr     = a;
        data_out = wd;
        tx_ready = rdy;
        #1;
    endtask

    task automatic load(input logic [31:0] a, input bit rdy);
        step(1'b1, 1'b1, 1'b1, a, 32'h0, rdy);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        step(1'b1, 1'b1, 1'b0, a, wd, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [7:0] drain_exp [8];

        rst_n = 1'b0; mem = 1'b0; mem_read = 1'b0; addr = '0; data_out = '0; tx_ready = 1'b0;

        //          m  rd  addr      wdata         rdy  din           valid txd    err
        vecs[0]  = '{0, 0, 32'h0,    32'h0,        0,   32'h0,        0,    8'h00, 0};
        vecs[1]  = '{1, 0, 32'h0,    32'h11111111, 0,   32'h0,        0,    8'h00, 0};
        vecs[2]  = '{1, 0, 32'h40,   32'hDEADBEEF, 0,   32'h0,        0,    8'h00, 0};
        vecs[3]  = '{1, 1, 32'h40,   32'h0,        0,   32'hDEADBEEF, 0,    8'h00, 0};
        vecs[4]  = '{1, 1, 32'h41,   32'h0,        0,   32'hDEADBEEF, 0,    8'h00, 0};
        vecs[5]  = '{1, 0, 32'd2048, 32'h12345678, 0,   32'h0,        0,    8'h00, 0};
        vecs[6]  = '{0, 0, 32'h0,    32'h0,        0,   32'h0,        0,    8'h00, 1};
        vecs[7]  = '{0, 0, 32'h0,    32'h0,        0,   32'h0,        0,    8'h00, 0};
        vecs[8]  = '{1, 1, 32'd2048, 32'h0,        0,   32'h0,        0,    8'h00, 0};
        vecs[9]  = '{1, 1, 32'h0,    32'h0,        0,   32'h11111111, 0,    8'h00, 1};
        vecs[10] = '{1, 1, 32'd1024, 32'h0,        0,   32'h00000002, 0,    8'h00, 0};
        vecs[11] = '{1, 1, 32'd1028, 32'h0,        0,   32'h0,        0,    8'h00, 0};
        vecs[12] = '{1, 0, 32'd1028, 32'h000000FF, 0,   32'h0,        0,    8'h00, 0};
        vecs[13] = '{1, 1, 32'd1028, 32'h0,        0,   32'h0,        0,    8'h00, 0};
        vecs[14] = '{1, 1, 32'h43,   32'h0,        0,   32'hDEADBEEF, 0,    8'h00, 0};

        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(1'b1, vecs[i].m, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].rdy);
            chk($sformatf("vec%0d data_in", i),  data_in,         vecs[i].exp_din);
            chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid),   32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d tx_data", i),  32'(tx_data),    32'(vecs[i].exp_txd));
            chk($sformatf("vec%0d bus_err", i),  32'(bus_err),    32'(vecs[i].exp_err));
        end

        // Console ordering: each byte appears one cycle after its push.
        for (int i = 0; i < 16; i++) begin
            store(32'd1024, 32'(i), 1'b1);
            chk($sformatf("order%0d tx_valid", i), 32'(tx_valid), (i > 0) ? 32'd1 : 32'd0);
            chk($sformatf("order%0d tx_data", i), 32'(tx_data), (i > 0) ? 32'(i - 1) : 32'd0);
        end
        idle(1'b1);
        chk("order tail valid", 32'(tx_valid), 32'd1);
        chk("order tail data", 32'(tx_data), 32'h0F);
        idle(1'b1);
        chk("order drained", 32'(tx_valid), 32'd0);
        load(32'd1028, 1'b0);
        chk("order no ovf", data_in, 32'h0);
        load(32'd1024, 1'b0);
        chk("order status", data_in, 32'h00000002);

        // Overflow: 10 pushes into 8 slots.
        for (int i = 0; i < 10; i++)
            store(32'd1024, 32'hA0 + 32'(i), 1'b0);
        load(32'd1024, 1'b0);
        chk("ovf status", data_in, 32'h00000805);
        chk("ovf head", 32'(tx_data), 32'hA0);
        load(32'd1028, 1'b0);
        chk("ovf count", data_in, 32'd2);
        load(32'd1028, 1'b0);
        chk("ovf cleared", data_in, 32'd0);
        load(32'd1024, 1'b0);
        chk("ovf status cleared", data_in, 32'h00000801);

        // Full with a pop in the same cycle as a push.
        store(32'd1024, 32'hB0, 1'b1);
        chk("fullpop head", 32'(tx_data), 32'hA0);
        load(32'd1024, 1'b0);
        chk("fullpop status", data_in, 32'h00000801);
        chk("fullpop next head", 32'(tx_data), 32'hA1);
        load(32'd1028, 1'b0);
        chk("fullpop ovf", data_in, 32'd0);
        drain_exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB0};
        for (int j = 0; j < 8; j++) begin
            idle(1'b1);
            chk($sformatf("drain%0d valid", j), 32'(tx_valid), 32'd1);
            chk($sformatf("drain%0d data", j), 32'(tx_data), 32'(drain_exp[j]));
        end
        idle(1'b0);
        chk("drain empty valid", 32'(tx_valid), 32'd0);
        chk("drain empty data", 32'(tx_data), 32'd0);

        // Mid-stream reset with 5 bytes queued.
        for (int i = 0; i < 5; i++)
            store(32'd1024, 32'hC0 + 32'(i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst pre valid", 32'(tx_valid), 32'd1);
        chk("rst pre data", 32'(tx_data), 32'hC0);
        load(32'd1024, 1'b0);
        chk("rst valid dropped", 32'(tx_valid), 32'd0);
        chk("rst status", data_in, 32'h00000002);
        load(32'd1028, 1'b0);
        chk("rst ovf", data_in, 32'd0);

        // Reset also clears a pending overflow count and bus error.
        for (int i = 0; i < 9; i++)
            store(32'd1024, 32'hD0 + 32'(i), 1'b0);
        store(32'd2048, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst2 pre bus_err", 32'(bus_err), 32'd1);
        load(32'd1028, 1'b0);
        chk("rst2 ovf", data_in, 32'd0);
        chk("rst2 bus_err", 32'(bus_err), 32'd0);
        chk("rst2 valid", 32'(tx_valid), 32'd0);
        load(32'd1024, 1'b0);
        chk("rst2 status", data_in, 32'h00000002);
        load(32'h40, 1'b0);
        chk("rst2 ram kept", data_in, 32'hDEADBEEF);

        idle(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
